// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: qualifies per-channel destination writes and holds them
// behind a valid/ready handshake, optionally with a two-entry skid buffer.
module mem_wb_pipe #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int CHANNELS = 1,
  parameter int SKID     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*ADDR_W-1:0]   mw_des_addr,
  input  logic [CHANNELS-1:0]          mw_des_exist,
  input  logic [CHANNELS*DATA_W-1:0]   mw_des_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*ADDR_W-1:0]   wb_des_addr,
  output logic [CHANNELS-1:0]          wb_des_exist,
  output logic [CHANNELS*DATA_W-1:0]   wb_des_data,
  output logic [1:0]                   occupancy
);

  localparam int AW = CHANNELS * ADDR_W;
  localparam int DW = CHANNELS * DATA_W;

  logic [CHANNELS-1:0] q_exist;

  // A channel loses its write if it targets r0 or a higher-index enabled channel
  // writes the same register in this instruction.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_qual
      logic shadowed;
      logic keep;
      always_comb begin
        shadowed = 1'b0;
        for (int j = gi + 1; j < CHANNELS; j++) begin
          if (mw_des_exist[j] &&
              (mw_des_addr[j*ADDR_W +: ADDR_W] == mw_des_addr[gi*ADDR_W +: ADDR_W]))
            shadowed = 1'b1;
        end
        keep = mw_des_exist[gi] && (mw_des_addr[gi*ADDR_W +: ADDR_W] != '0) && !shadowed;
      end
      assign q_exist[gi] = keep;
    end
  endgenerate

  logic            main_valid_reg, main_valid_next;
  logic [AW-1:0]   main_addr_reg,  main_addr_next;
  logic [CHANNELS-1:0] main_exist_reg, main_exist_next;
  logic [DW-1:0]   main_data_reg,  main_data_next;
  logic            skid_valid_reg, skid_valid_next;
  logic [AW-1:0]   skid_addr_reg,  skid_addr_next;
  logic [CHANNELS-1:0] skid_exist_reg, skid_exist_next;
  logic [DW-1:0]   skid_data_reg,  skid_data_next;
  logic [1:0]      occ_reg,        occ_next;

  logic in_xfer;
  logic out_xfer;

  generate
    if (SKID != 0) begin : g_ready_skid
      assign in_ready = !skid_valid_reg;
    end else begin : g_ready_pass
      assign in_ready = !main_valid_reg || out_ready;
    end
  endgenerate

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_valid_reg && out_ready;

  always_comb begin
    main_valid_next = main_valid_reg;
    main_addr_next  = main_addr_reg;
    main_exist_next = main_exist_reg;
    main_data_next  = main_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_addr_next  = skid_addr_reg;
    skid_exist_next = skid_exist_reg;
    skid_data_next  = skid_data_reg;

    if (flush) begin
      main_valid_next = 1'b0;
      main_addr_next  = '0;
      main_exist_next = '0;
      main_data_next  = '0;
      skid_valid_next = 1'b0;
      skid_addr_next  = '0;
      skid_exist_next = '0;
      skid_data_next  = '0;
    end else if (SKID != 0) begin
      if (out_xfer || !main_valid_reg) begin
        // Main is free this cycle; a held skid beat always has priority.
        if (skid_valid_reg) begin
          main_valid_next = 1'b1;
          main_addr_next  = skid_addr_reg;
          main_exist_next = skid_exist_reg;
          main_data_next  = skid_data_reg;
          skid_valid_next = 1'b0;
          skid_addr_next  = '0;
          skid_exist_next = '0;
          skid_data_next  = '0;
        end else if (in_xfer) begin
          main_valid_next = 1'b1;
          main_addr_next  = mw_des_addr;
          main_exist_next = q_exist;
          main_data_next  = mw_des_data;
        end else begin
          main_valid_next = 1'b0;
          main_addr_next  = '0;
          main_exist_next = '0;
          main_data_next  = '0;
        end
      end else if (in_xfer) begin
        skid_valid_next = 1'b1;
        skid_addr_next  = mw_des_addr;
        skid_exist_next = q_exist;
        skid_data_next  = mw_des_data;
      end
    end else begin
      if (in_xfer) begin
        main_valid_next = 1'b1;
        main_addr_next  = mw_des_addr;
        main_exist_next = q_exist;
        main_data_next  = mw_des_data;
      end else if (out_xfer) begin
        main_valid_next = 1'b0;
        main_addr_next  = '0;
        main_exist_next = '0;
        main_data_next  = '0;
      end
    end

    occ_next = {1'b0, main_valid_next} + {1'b0, skid_valid_next};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_reg <= 1'b0;
      main_addr_reg  <= '0;
      main_exist_reg <= '0;
      main_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      skid_addr_reg  <= '0;
      skid_exist_reg <= '0;
      skid_data_reg  <= '0;
      occ_reg        <= 2'd0;
    end else begin
      main_valid_reg <= main_valid_next;
      main_addr_reg  <= main_addr_next;
      main_exist_reg <= main_exist_next;
      main_data_reg  <= main_data_next;
      skid_valid_reg <= skid_valid_next;
      skid_addr_reg  <= skid_addr_next;
      skid_exist_reg <= skid_exist_next;
      skid_data_reg  <= skid_data_next;
      occ_reg        <= occ_next;
    end
  end

  assign out_valid    = main_valid_reg;
  assign wb_des_addr  = main_addr_reg;
  assign wb_des_exist = main_exist_reg;
  assign wb_des_data  = main_data_reg;
  assign occupancy    = occ_reg;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: skid and pass-through variants plus a
// three-channel instance for r0/conflict qualification.
module tb_mem_wb_pipe;

  logic clk;
  logic rst;

  // s1: SKID=1, CHANNELS=1
  logic        s1_flush, s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
  logic [4:0]  s1_addr, s1_wb_addr;
  logic [0:0]  s1_exist, s1_wb_exist;
  logic [31:0] s1_data, s1_wb_data;
  logic [1:0]  s1_occ;

  // c3: SKID=1, CHANNELS=3
  logic        c3_flush, c3_in_valid, c3_in_ready, c3_out_valid, c3_out_ready;
  logic [14:0] c3_addr, c3_wb_addr;
  logic [2:0]  c3_exist, c3_wb_exist;
  logic [95:0] c3_data, c3_wb_data;
  logic [1:0]  c3_occ;

  // n0: SKID=0, CHANNELS=1
  logic        n0_flush, n0_in_valid, n0_in_ready, n0_out_valid, n0_out_ready;
  logic [4:0]  n0_addr, n0_wb_addr;
  logic [0:0]  n0_exist, n0_wb_exist;
  logic [31:0] n0_data, n0_wb_data;
  logic [1:0]  n0_occ;

  int total = 0;
  int bad   = 0;

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .CHANNELS(1), .SKID(1)) dut_s1 (
    .clk(clk), .rst(rst), .flush(s1_flush), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
    .mw_des_addr(s1_addr), .mw_des_exist(s1_exist), .mw_des_data(s1_data),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready), .wb_des_addr(s1_wb_addr),
    .wb_des_exist(s1_wb_exist), .wb_des_data(s1_wb_data), .occupancy(s1_occ)
  );

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .CHANNELS(3), .SKID(1)) dut_c3 (
    .clk(clk), .rst(rst), .flush(c3_flush), .in_valid(c3_in_valid), .in_ready(c3_in_ready),
    .mw_des_addr(c3_addr), .mw_des_exist(c3_exist), .mw_des_data(c3_data),
    .out_valid(c3_out_valid), .out_ready(c3_out_ready), .wb_des_addr(c3_wb_addr),
    .wb_des_exist(c3_wb_exist), .wb_des_data(c3_wb_data), .occupancy(c3_occ)
  );

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .CHANNELS(1), .SKID(0)) dut_n0 (
    .clk(clk), .rst(rst), .flush(n0_flush), .in_valid(n0_in_valid), .in_ready(n0_in_ready),
    .mw_des_addr(n0_addr), .mw_des_exist(n0_exist), .mw_des_data(n0_data),
    .out_valid(n0_out_valid), .out_ready(n0_out_ready), .wb_des_addr(n0_wb_addr),
    .wb_des_exist(n0_wb_exist), .wb_des_data(n0_wb_data), .occupancy(n0_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_s1(input string tag, input logic v, input logic [31:0] d, input logic [1:0] occ);
    check({tag, ".valid"}, 128'(s1_out_valid), 128'(v));
    check({tag, ".data"},  128'(s1_wb_data),   128'(d));
    check({tag, ".occ"},   128'(s1_occ),       128'(occ));
  endtask

  // Conflict/r0 vectors: {ch2, ch1, ch0} addresses, exist in, expected exist out
  logic [14:0] tab_addr [6];
  logic [2:0]  tab_exist[6];
  logic [2:0]  tab_exp  [6];

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    tab_addr[0] = {5'd7, 5'd7, 5'd0}; tab_exist[0] = 3'b111; tab_exp[0] = 3'b100;
    tab_addr[1] = {5'd9, 5'd4, 5'd4}; tab_exist[1] = 3'b011; tab_exp[1] = 3'b010;
    tab_addr[2] = {5'd4, 5'd0, 5'd4}; tab_exist[2] = 3'b101; tab_exp[2] = 3'b100;
    tab_addr[3] = {5'd3, 5'd2, 5'd1}; tab_exist[3] = 3'b111; tab_exp[3] = 3'b111;
    tab_addr[4] = {5'd5, 5'd5, 5'd5}; tab_exist[4] = 3'b111; tab_exp[4] = 3'b100;
    tab_addr[5] = {5'd6, 5'd5, 5'd6}; tab_exist[5] = 3'b011; tab_exp[5] = 3'b011;

    rst = 1'b1;
    s1_flush = 0; s1_in_valid = 0; s1_out_ready = 0; s1_addr = 0; s1_exist = 0; s1_data = 0;
    c3_flush = 0; c3_in_valid = 0; c3_out_ready = 0; c3_addr = 0; c3_exist = 0; c3_data = 0;
    n0_flush = 0; n0_in_valid = 0; n0_out_ready = 0; n0_addr = 0; n0_exist = 0; n0_data = 0;
    #1 rst = 1'b0;
    #1;
    check_s1("reset", 1'b0, 32'h0, 2'd0);
    check("reset.in_ready", 128'(s1_in_ready), 128'(1'b1));
    check("reset.n0_in_ready", 128'(n0_in_ready), 128'(1'b1));
    tick;
    rst = 1'b1;
    tick;

    // Streaming: one beat per cycle, each visible one cycle after input
    s1_in_valid = 1; s1_out_ready = 1; s1_addr = 5'd3; s1_exist = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s1_data = 32'h10 + 32'(i);
      tick;
      check_s1($sformatf("stream%0d", i), 1'b1, 32'h10 + 32'(i), 2'd1);
      check($sformatf("stream%0d.addr", i), 128'(s1_wb_addr), 128'(5'd3));
    end
    s1_in_valid = 0;
    tick;
    check_s1("stream.bubble", 1'b0, 32'h0, 2'd0);
    check("stream.bubble_addr", 128'(s1_wb_addr), 128'(5'd0));

    // Back-pressure through the skid entry
    s1_out_ready = 0; s1_in_valid = 1; s1_data = 32'hA;
    tick;
    check_s1("bp.a", 1'b1, 32'hA, 2'd1);
    check("bp.a.in_ready", 128'(s1_in_ready), 128'(1'b1));
    s1_data = 32'hB;
    tick;
    check_s1("bp.b_skid", 1'b1, 32'hA, 2'd2);
    check("bp.b.in_ready", 128'(s1_in_ready), 128'(1'b0));
    s1_data = 32'hC;
    tick;
    check_s1("bp.hold", 1'b1, 32'hA, 2'd2);
    s1_out_ready = 1;
    tick;
    check_s1("bp.drain_b", 1'b1, 32'hB, 2'd1);
    check("bp.drain.in_ready", 128'(s1_in_ready), 128'(1'b1));
    tick;
    s1_in_valid = 0;
    check_s1("bp.c", 1'b1, 32'hC, 2'd1);
    tick;
    check_s1("bp.empty", 1'b0, 32'h0, 2'd0);

    // Conflict / r0 qualification
    c3_out_ready = 1; c3_in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      c3_addr  = tab_addr[i];
      c3_exist = tab_exist[i];
      c3_data  = {32'(i + 3), 32'(i + 2), 32'(i + 1)};
      tick;
      check($sformatf("conf%0d.exist", i), 128'(c3_wb_exist), 128'(tab_exp[i]));
      check($sformatf("conf%0d.addr", i),  128'(c3_wb_addr),  128'(tab_addr[i]));
      check($sformatf("conf%0d.data", i),  128'(c3_wb_data),
            128'({32'(i + 3), 32'(i + 2), 32'(i + 1)}));
    end
    c3_in_valid = 0;
    tick;
    check("conf.bubble_exist", 128'(c3_wb_exist), 128'(3'b000));

    // Flush with both entries full, 0x55 offered
    s1_out_ready = 0; s1_in_valid = 1; s1_data = 32'h1;
    tick;
    s1_data = 32'h2;
    tick;
    check_s1("flush.full", 1'b1, 32'h1, 2'd2);
    s1_flush = 1; s1_data = 32'h55;
    tick;
    s1_flush = 0; s1_in_valid = 0;
    check_s1("flush.cleared", 1'b0, 32'h0, 2'd0);
    check("flush.in_ready", 128'(s1_in_ready), 128'(1'b1));
    s1_out_ready = 1;
    tick;
    check_s1("flush.no55", 1'b0, 32'h0, 2'd0);
    // Flush coinciding with an accepted in-transfer of 0x55
    s1_out_ready = 0; s1_in_valid = 1; s1_data = 32'h3;
    tick;
    s1_flush = 1; s1_data = 32'h55;
    #1 check("flush2.xfer_ready", 128'(s1_in_ready), 128'(1'b1));
    tick;
    s1_flush = 0; s1_in_valid = 0; s1_out_ready = 1;
    check_s1("flush2.cleared", 1'b0, 32'h0, 2'd0);
    tick;
    check_s1("flush2.no55", 1'b0, 32'h0, 2'd0);

    // SKID=0: combinational ready follows out_ready
    n0_out_ready = 0; n0_in_valid = 1; n0_addr = 5'd2; n0_exist = 1'b1; n0_data = 32'h40;
    tick;
    n0_data = 32'h41;
    #1;
    check("n0.full.in_ready", 128'(n0_in_ready), 128'(1'b0));
    check("n0.full.data", 128'(n0_wb_data), 128'(32'h40));
    tick;
    check("n0.hold.data", 128'(n0_wb_data), 128'(32'h40));
    n0_out_ready = 1;
    #1;
    check("n0.release.in_ready", 128'(n0_in_ready), 128'(1'b1));
    tick;
    n0_in_valid = 0;
    check("n0.next.data", 128'(n0_wb_data), 128'(32'h41));
    check("n0.next.occ", 128'(n0_occ), 128'(2'd1));
    tick;
    check("n0.empty.valid", 128'(n0_out_valid), 128'(1'b0));

    // Asynchronous reset mid-transfer, no clock edge needed
    s1_out_ready = 0; s1_in_valid = 1; s1_data = 32'h77;
    tick;
    check_s1("arst.pre", 1'b1, 32'h77, 2'd1);
    #2 rst = 1'b0; s1_in_valid = 0;
    #1;
    check_s1("arst.now", 1'b0, 32'h0, 2'd0);
    check("arst.exist", 128'(s1_wb_exist), 128'(1'b0));
    check("arst.in_ready", 128'(s1_in_ready), 128'(1'b1));
    tick;
    rst = 1'b1;
    tick;
    check_s1("arst.after", 1'b0, 32'h0, 2'd0);
    check("arst.after.in_ready", 128'(s1_in_ready), 128'(1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
